// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers; one shift-add or restoring
// shift-subtract step per cycle. Define MULDIV_EARLY_EXIT_EN for early multiply completion.
module muldiv_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwe,
    input  logic             lowe,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SIGN} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             is_div_reg, is_div_next;
    logic             neg_lo_reg, neg_lo_next;
    logic             neg_hi_reg, neg_hi_next;
    logic             dz_reg, dz_next;
    logic [WIDTH-1:0] raw_a_reg, raw_a_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] mq_reg, mq_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             done_reg, done_next;
    logic             divzero_reg, divzero_next;

    // acc holds the running product high half / partial remainder;
    // mq holds multiplier-then-product low half / dividend-then-quotient.
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     div_shifted;
    logic               div_ge;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_signed   = ~op[0];
    assign abs_a       = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    assign abs_b       = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;
    assign div_shifted = {acc_reg, mq_reg[WIDTH-1]};
    assign div_ge      = div_shifted >= {1'b0, b_reg};
    assign mul_sum     = {1'b0, acc_reg} + (mq_reg[0] ? {1'b0, b_reg} : '0);
    assign prod        = {acc_reg, mq_reg};
    assign prod_fix    = neg_lo_reg ? -prod : prod;
    assign quot_fix    = neg_lo_reg ? -mq_reg : mq_reg;
    assign rem_fix     = neg_hi_reg ? -acc_reg : acc_reg;

`ifdef MULDIV_EARLY_EXIT_EN
    // Multiplier bits not yet consumed are mq[cnt:0]; once they are all zero the
    // remaining steps are pure shifts and collapse into one.
    logic [WIDTH-1:0]   rem_mask;
    logic               mul_tail_zero;
    logic [2*WIDTH-1:0] prod_tail;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rem_mask
            assign rem_mask[gi] = (CNT_W'(gi) <= cnt_reg);
        end
    endgenerate

    assign mul_tail_zero = ~|(mq_reg & rem_mask);
    assign prod_tail     = prod >> (cnt_reg + CNT_W'(1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            is_div_reg  <= 1'b0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            dz_reg      <= 1'b0;
            raw_a_reg   <= '0;
            acc_reg     <= '0;
            mq_reg      <= '0;
            b_reg       <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
            divzero_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            is_div_reg  <= is_div_next;
            neg_lo_reg  <= neg_lo_next;
            neg_hi_reg  <= neg_hi_next;
            dz_reg      <= dz_next;
            raw_a_reg   <= raw_a_next;
            acc_reg     <= acc_next;
            mq_reg      <= mq_next;
            b_reg       <= b_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            done_reg    <= done_next;
            divzero_reg <= divzero_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        is_div_next  = is_div_reg;
        neg_lo_next  = neg_lo_reg;
        neg_hi_next  = neg_hi_reg;
        dz_next      = dz_reg;
        raw_a_next   = raw_a_reg;
        acc_next     = acc_reg;
        mq_next      = mq_reg;
        b_next       = b_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        done_next    = 1'b0;
        divzero_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (hiwe) hi_next = wdata;
                if (lowe) lo_next = wdata;
                if (start && !flush) begin
                    state_next  = ST_RUN;
                    cnt_next    = CNT_W'(WIDTH - 1);
                    is_div_next = op[1];
                    neg_lo_next = is_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    neg_hi_next = is_signed & srca[WIDTH-1];
                    dz_next     = op[1] & (srcb == '0);
                    raw_a_next  = srca;
                    acc_next    = '0;
                    mq_next     = op[1] ? abs_a : abs_b;
                    b_next      = op[1] ? abs_b : abs_a;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) state_next = ST_SIGN;
                    if (is_div_reg) begin
                        acc_next = div_ge ? WIDTH'(div_shifted - {1'b0, b_reg})
                                          : div_shifted[WIDTH-1:0];
                        mq_next  = {mq_reg[WIDTH-2:0], div_ge};
                    end else
`ifdef MULDIV_EARLY_EXIT_EN
                    if (mul_tail_zero) begin
                        {acc_next, mq_next} = prod_tail;
                        cnt_next            = '0;
                        state_next          = ST_SIGN;
                    end else
`endif
                    begin
                        {acc_next, mq_next} = {mul_sum, mq_reg[WIDTH-1:1]};
                    end
                end
            end
            ST_SIGN: begin
                state_next = ST_IDLE;
                // An abort arriving in the writeback cycle still wins.
                if (!flush) begin
                    done_next    = 1'b1;
                    divzero_next = dz_reg;
                    if (!is_div_reg) begin
                        {hi_next, lo_next} = prod_fix;
                    end else if (dz_reg) begin
                        hi_next = raw_a_reg;
                        lo_next = '1;
                    end else begin
                        hi_next = rem_fix;
                        lo_next = quot_fix;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign divzero = divzero_reg;
    assign hi      = hi_reg;
    assign lo      = lo_reg;

endmodule
